// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port frame buffer between 2x-upscaled VGA scan-out and one writer
module vga_fb_arbiter #(
    parameter int WIDTH_COLOR = 12,
    parameter int WIDTH_POS = 10,
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int ADDR_W = 17,
    parameter logic [WIDTH_COLOR-1:0] BORDER_COLOR = 12'h000
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    input  logic [WIDTH_POS-1:0]   xpos,
    input  logic [WIDTH_POS-1:0]   ypos,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   en_in,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH_COLOR-1:0] wr_data,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [WIDTH_COLOR-1:0] ram_wdata,
    input  logic [WIDTH_COLOR-1:0] ram_rdata,
    output logic [WIDTH_COLOR-1:0] color,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   en_out,
    output logic                   frame_start,
    output logic                   oob_err
);
    localparam logic [WIDTH_POS-1:0] FBW = WIDTH_POS'(FB_W);
    localparam logic [WIDTH_POS-1:0] FBH = WIDTH_POS'(FB_H);
    localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FB_W);
    localparam logic [ADDR_W:0] FB_N = (ADDR_W+1)'(FB_W * FB_H);

    logic [WIDTH_POS-1:0] fx, fy;
    logic in_fb, slot, rd_slot, wr_hit, wr_go, wr_oob;
    logic [ADDR_W-1:0] rd_addr, addr_q;
    logic [WIDTH_COLOR-1:0] wdata_q, pix_hold;
    logic s1_rd, s1_en, s1_in_fb, s1_hs, s1_vs, s1_fs;

    assign fx = xpos >> 1;
    assign fy = ypos >> 1;
    assign in_fb = (fx < FBW) && (fy < FBH);
    assign slot = en_in && in_fb && !xpos[0];
    assign rd_slot = !rst && slot;
    assign wr_ready = !rst && !slot;
    assign wr_hit = wr_ready && wr_valid;
    assign wr_go = wr_hit && ({1'b0, wr_addr} < FB_N);
    assign wr_oob = wr_hit && !({1'b0, wr_addr} < FB_N);
    assign rd_addr = ADDR_W'(fy) * FBW_A + ADDR_W'(fx);

    // BRAM port mux: scan-out reads win, writer fills the rest, idle holds address/data
    always_comb begin
        ram_en = rd_slot || wr_go;
        ram_we = wr_go;
        ram_addr = rst ? '0 : rd_slot ? rd_addr : wr_go ? wr_addr : addr_q;
        ram_wdata = rst ? '0 : wr_go ? wr_data : wdata_q;
    end

    // last driven address/data, reused on idle cycles; sticky out-of-range flag
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            addr_q <= '0;
            wdata_q <= '0;
            oob_err <= 1'b0;
        end else begin
            if (ram_en) begin
                addr_q <= ram_addr;
                wdata_q <= ram_wdata;
            end
            if (wr_oob) oob_err <= 1'b1;
        end
    end

    // two-stage scan-out pipeline; odd columns replay pix_hold for the horizontal doubling
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            {s1_rd, s1_en, s1_in_fb, s1_hs, s1_vs, s1_fs} <= '0;
            pix_hold <= '0;
            color <= '0;
            {hsync_out, vsync_out, en_out, frame_start} <= '0;
        end else begin
            s1_rd <= rd_slot;
            s1_en <= en_in;
            s1_in_fb <= in_fb;
            s1_hs <= hsync_in;
            s1_vs <= vsync_in;
            s1_fs <= (xpos == '0) && (ypos == '0);
            if (s1_rd) pix_hold <= ram_rdata;
            color <= !s1_en ? '0 : !s1_in_fb ? BORDER_COLOR : s1_rd ? ram_rdata : pix_hold;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
            en_out <= s1_en;
            frame_start <= s1_fs;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of arbitration, scan-out pipeline and flags
module tb_vga_fb_arbiter;
    logic pixel_clk = 0;
    logic rst = 1;
    logic [9:0] xpos = 0, ypos = 0;
    logic hsync_in = 0, vsync_in = 0, en_in = 0;
    logic wr_valid = 0;
    logic [16:0] wr_addr = 0;
    logic [11:0] wr_data = 0;
    logic wr_ready, ram_en, ram_we, hsync_out, vsync_out, en_out, frame_start, oob_err;
    logic [16:0] ram_addr;
    logic [11:0] ram_wdata, ram_rdata, color;
    logic wr_ready2, ram_en2, ram_we2, hs2, vs2, en2, fs2, oob2;
    logic [16:0] ram_addr2;
    logic [11:0] ram_wdata2, color2;
    logic [11:0] rdata2 = 12'h555;
    logic [11:0] mem [0:(1<<17)-1];
    int n_pass = 0, n_total = 0;

    vga_fb_arbiter u_dut (
        .pixel_clk(pixel_clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .en_in(en_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .color(color), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .en_out(en_out), .frame_start(frame_start), .oob_err(oob_err)
    );

    vga_fb_arbiter #(.FB_W(300), .BORDER_COLOR(12'h5A5)) u_dut2 (
        .pixel_clk(pixel_clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .en_in(en_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_rdata(rdata2), .color(color2), .hsync_out(hs2), .vsync_out(vs2),
        .en_out(en2), .frame_start(fs2), .oob_err(oob2)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic en,
                         input logic hs, input logic vs, input logic wv,
                         input logic [16:0] wa, input logic [11:0] wd);
        xpos = x; ypos = y; en_in = en; hsync_in = hs; vsync_in = vs;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
    endtask

    task automatic tick;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            drive(10'd700, 10'd0, 0, 0, 0, 1, 17'd5, 12'h123);
            n_total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got %b want 0", wr_ready); else n_pass++;
            n_total++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en got %b want 0", ram_en); else n_pass++;
            tick;
        end
        n_total++; if (color !== 12'h000) $display("FAIL reset_color got %h want 000", color); else n_pass++;
        n_total++; if (oob_err !== 1'b0) $display("FAIL reset_oob got %b want 0", oob_err); else n_pass++;
        rst = 0;
        drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd0, 12'h000);
        n_total++; if (wr_ready !== 1'b1) $display("FAIL post_reset_wr_ready got %b want 1", wr_ready); else n_pass++;
        n_total++; if (ram_en !== 1'b0) $display("FAIL idle_ram_en got %b want 0", ram_en); else n_pass++;
        tick;
    endtask

    task automatic test_preload;
        drive(10'd700, 10'd0, 0, 0, 0, 1, 17'd0, 12'hF00);
        n_total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 17'd0, 12'hF00})
            $display("FAIL preload0 got en=%b we=%b a=%0d d=%h want 1 1 0 F00", ram_en, ram_we, ram_addr, ram_wdata); else n_pass++;
        tick;
        drive(10'd700, 10'd0, 0, 0, 0, 1, 17'd1, 12'h0F0);
        n_total++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 17'd1, 12'h0F0})
            $display("FAIL preload1 got en=%b we=%b a=%0d d=%h want 1 1 1 0F0", ram_en, ram_we, ram_addr, ram_wdata); else n_pass++;
        tick;
        drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd9, 12'h777);
        n_total++; if ({ram_en, ram_addr, ram_wdata} !== {1'b0, 17'd1, 12'h0F0})
            $display("FAIL idle_hold got en=%b a=%0d d=%h want 0 1 0F0", ram_en, ram_addr, ram_wdata); else n_pass++;
        tick;
    endtask

    task automatic test_scan_read;
        logic [11:0] exp_c [0:3];
        logic [3:0] hp, vp;
        exp_c[0] = 12'hF00; exp_c[1] = 12'hF00; exp_c[2] = 12'h0F0; exp_c[3] = 12'h0F0;
        hp = 4'b1011; vp = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(10'(i), 10'd0, 1, hp[i], vp[i], 0, 17'd0, 12'h000);
            else drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd0, 12'h000);
            if (i == 0) begin
                n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 17'd0})
                    $display("FAIL scan_addr_x0 got en=%b we=%b a=%0d want 1 0 0", ram_en, ram_we, ram_addr); else n_pass++;
            end
            if (i == 2) begin
                n_total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 17'd1})
                    $display("FAIL scan_addr_x2 got en=%b we=%b a=%0d want 1 0 1", ram_en, ram_we, ram_addr); else n_pass++;
            end
            tick;
            if (i >= 1) begin
                n_total++; if (color !== exp_c[i-1]) $display("FAIL scan_color x=%0d got %h want %h", i-1, color, exp_c[i-1]); else n_pass++;
                n_total++; if ({hsync_out, vsync_out, en_out} !== {hp[i-1], vp[i-1], 1'b1})
                    $display("FAIL scan_sync x=%0d got %b%b%b want %b%b1", i-1, hsync_out, vsync_out, en_out, hp[i-1], vp[i-1]); else n_pass++;
            end
        end
        tick;
        n_total++; if ({color, en_out} !== {12'h000, 1'b0}) $display("FAIL blank_color got %h en=%b want 000 0", color, en_out); else n_pass++;
    endtask

    task automatic test_row_double;
        drive(10'd4, 10'd5, 1, 0, 0, 0, 17'd0, 12'h000);
        n_total++; if (ram_addr !== 17'd642) $display("FAIL row_y5 got %0d want 642", ram_addr); else n_pass++;
        tick;
        drive(10'd4, 10'd4, 1, 0, 0, 0, 17'd0, 12'h000);
        n_total++; if (ram_addr !== 17'd642) $display("FAIL row_y4 got %0d want 642", ram_addr); else n_pass++;
        tick;
        drive(10'd5, 10'd4, 1, 0, 0, 0, 17'd0, 12'h000);
        n_total++; if ({wr_ready, ram_en} !== 2'b10) $display("FAIL odd_col got rdy=%b en=%b want 1 0", wr_ready, ram_en); else n_pass++;
        tick;
    endtask

    task automatic test_arbitration;
        for (int i = 0; i < 4; i++) begin
            drive(10'(i), 10'd0, 1, 0, 0, 1, 17'd100, 12'hABC);
            n_total++; if ({wr_ready, ram_we} !== {i[0], i[0]})
                $display("FAIL arb x=%0d got rdy=%b we=%b want %b %b", i, wr_ready, ram_we, i[0], i[0]); else n_pass++;
            if (i[0]) begin
                n_total++; if (ram_addr !== 17'd100) $display("FAIL arb_addr x=%0d got %0d want 100", i, ram_addr); else n_pass++;
            end
            tick;
        end
        drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd0, 12'h000);
        tick;
        drive(10'd200, 10'd1, 1, 0, 0, 0, 17'd0, 12'h000);
        tick;
        drive(10'd201, 10'd1, 1, 0, 0, 0, 17'd0, 12'h000);
        tick;
        n_total++; if (color !== 12'hABC) $display("FAIL readback got %h want ABC", color); else n_pass++;
        drive(10'd700, 10'd1, 0, 0, 0, 0, 17'd0, 12'h000);
        tick;
        n_total++; if (color !== 12'hABC) $display("FAIL readback_odd got %h want ABC", color); else n_pass++;
    endtask

    task automatic test_oob;
        drive(10'd700, 10'd0, 0, 0, 0, 1, 17'd76799, 12'h321);
        n_total++; if ({wr_ready, ram_en, ram_we} !== 3'b111) $display("FAIL last_addr got %b want 111", {wr_ready, ram_en, ram_we}); else n_pass++;
        tick;
        n_total++; if (oob_err !== 1'b0) $display("FAIL last_addr_oob got %b want 0", oob_err); else n_pass++;
        drive(10'd700, 10'd0, 0, 0, 0, 1, 17'd76800, 12'h321);
        n_total++; if ({wr_ready, ram_en} !== 2'b10) $display("FAIL oob_write got rdy=%b en=%b want 1 0", wr_ready, ram_en); else n_pass++;
        tick;
        n_total++; if (oob_err !== 1'b1) $display("FAIL oob_set got %b want 1", oob_err); else n_pass++;
        drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd0, 12'h000);
        tick;
        tick;
        n_total++; if (oob_err !== 1'b1) $display("FAIL oob_sticky got %b want 1", oob_err); else n_pass++;
    endtask

    task automatic test_border;
        drive(10'd600, 10'd0, 1, 0, 0, 0, 17'd0, 12'h000);
        n_total++; if ({wr_ready2, ram_en2} !== 2'b10) $display("FAIL border_slot got rdy=%b en=%b want 1 0", wr_ready2, ram_en2); else n_pass++;
        tick;
        drive(10'd700, 10'd0, 0, 0, 0, 0, 17'd0, 12'h000);
        tick;
        n_total++; if (color2 !== 12'h5A5) $display("FAIL border_color got %h want 5A5", color2); else n_pass++;
        tick;
        n_total++; if (color2 !== 12'h000) $display("FAIL border_blank got %h want 000", color2); else n_pass++;
    endtask

    task automatic test_frame_start;
        for (int i = 0; i < 5; i++) begin
            drive(10'(i), 10'd0, 1, 0, 0, 0, 17'd0, 12'h000);
            tick;
            if (i >= 1) begin
                n_total++; if (frame_start !== (i == 1)) $display("FAIL frame_start i=%0d got %b want %b", i, frame_start, i == 1); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_preload;
        test_scan_read;
        test_row_double;
        test_arbitration;
        test_oob;
        test_border;
        test_frame_start;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
